// File: rtl/rr_arbiter_pkg.sv
// +-----------------------------------------------------------------------+
// | rr_arb_pkg: shared types and helpers for the round-robin arbiter.     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package rr_arb_pkg;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

   localparam int C_MAX_REQ = 32;

   // OR of set-bit positions; exact for one-hot and zero inputs.
   function automatic int onehot_to_idx(input logic [C_MAX_REQ-1:0] vec);
      int idx;
      idx = 0;
      for (int k = 0; k < C_MAX_REQ; k++) begin
         if (vec[k]) begin
            idx = idx | k;
         end
      end
      return idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_if.sv
// +-----------------------------------------------------------------------+
// | rr_arbiter_if: request/grant bundle between requesters and arbiter.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

interface rr_arbiter_if
   import rr_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] req_i;
   logic               mode_i;
   logic               hold_i;
   logic [NUM_REQ-1:0] grant_o;
   logic [ID_W-1:0]    grant_id_o;
   logic               grant_valid_o;

   modport master (
      output req_i, mode_i, hold_i,
      input  grant_o, grant_id_o, grant_valid_o
   );

   modport slave (
      input  req_i, mode_i, hold_i,
      output grant_o, grant_id_o, grant_valid_o
   );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter_prio_pick.sv
// +-----------------------------------------------------------------------+
// | prio_pick: lowest-set-bit one-hot select with an any-set flag.        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module prio_pick #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] vec_i,
   output logic [WIDTH-1:0] pick_o,
   output logic             any_o
);

   // Two's-complement trick isolates the lowest set bit.
   assign pick_o = vec_i & (~vec_i + WIDTH'(1));
   assign any_o  = |vec_i;

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +-----------------------------------------------------------------------+
// | rr_arbiter: registered fixed-priority / round-robin arbiter with hold.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module rr_arbiter
   import rr_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   rr_arbiter_if.slave arb
);

   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] r_grant;
   logic [ID_W-1:0]    r_grant_id;
   logic               r_grant_valid;
   logic [ID_W-1:0]    r_ptr;

   logic [NUM_REQ-1:0] w_nxt_grant;
   logic [ID_W-1:0]    w_nxt_grant_id;
   logic               w_nxt_grant_valid;
   logic [ID_W-1:0]    w_nxt_ptr;

   logic [NUM_REQ-1:0] w_mask;
   logic [NUM_REQ-1:0] w_req_masked;
   logic [NUM_REQ-1:0] w_pick_masked;
   logic [NUM_REQ-1:0] w_pick_full;
   logic [NUM_REQ-1:0] w_pick_rr;
   logic               w_any_masked;
   logic               w_any_full;
   logic [ID_W-1:0]    w_idx_full;
   logic [ID_W-1:0]    w_idx_rr;
   logic               w_hold;
   arb_mode_e          w_mode;

   // Requesters below the pointer are deferred to the wrap-around pick.
   assign w_mask       = ~((NUM_REQ'(1) << r_ptr) - NUM_REQ'(1));
   assign w_req_masked = arb.req_i & w_mask;

   prio_pick #(.WIDTH(NUM_REQ)) u_pick_masked (
      .vec_i  (w_req_masked),
      .pick_o (w_pick_masked),
      .any_o  (w_any_masked)
   );

   prio_pick #(.WIDTH(NUM_REQ)) u_pick_full (
      .vec_i  (arb.req_i),
      .pick_o (w_pick_full),
      .any_o  (w_any_full)
   );

   assign w_pick_rr  = w_any_masked ? w_pick_masked : w_pick_full;
   assign w_idx_full = ID_W'(onehot_to_idx(C_MAX_REQ'(w_pick_full)));
   assign w_idx_rr   = ID_W'(onehot_to_idx(C_MAX_REQ'(w_pick_rr)));
   assign w_mode     = arb_mode_e'(arb.mode_i);
   assign w_hold     = arb.hold_i && r_grant_valid && arb.req_i[r_grant_id];

   always_comb begin
      w_nxt_grant       = r_grant;
      w_nxt_grant_id    = r_grant_id;
      w_nxt_grant_valid = r_grant_valid;
      w_nxt_ptr         = r_ptr;
      if (w_hold) begin
         w_nxt_grant = r_grant;
      end else if (!w_any_full) begin
         w_nxt_grant       = '0;
         w_nxt_grant_valid = 1'b0;
      end else if (w_mode == ARB_FIXED) begin
         w_nxt_grant       = w_pick_full;
         w_nxt_grant_id    = w_idx_full;
         w_nxt_grant_valid = 1'b1;
      end else begin
         w_nxt_grant       = w_pick_rr;
         w_nxt_grant_id    = w_idx_rr;
         w_nxt_grant_valid = 1'b1;
         w_nxt_ptr         = (w_idx_rr == ID_W'(NUM_REQ - 1)) ? '0 : w_idx_rr + ID_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_grant       <= '0;
         r_grant_id    <= '0;
         r_grant_valid <= 1'b0;
         r_ptr         <= '0;
      end else begin
         r_grant       <= w_nxt_grant;
         r_grant_id    <= w_nxt_grant_id;
         r_grant_valid <= w_nxt_grant_valid;
         r_ptr         <= w_nxt_ptr;
      end
   end

   assign arb.grant_o       = r_grant;
   assign arb.grant_id_o    = r_grant_id;
   assign arb.grant_valid_o = r_grant_valid;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter.sv
// +-----------------------------------------------------------------------+
// | tb_rr_arbiter: directed + random bench with a behavioural model.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_rr_arbiter;

   localparam int NR = 4;

   logic clk = 1'b0;
   logic reset_n;
   bit   check_en = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;

   rr_arbiter_if #(.NUM_REQ(NR)) bus ();

   rr_arbiter #(.NUM_REQ(NR)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .arb     (bus.slave)
   );

   always #5 clk = ~clk;

   // Model state: who holds the grant, and where round-robin search starts.
   bit         m_valid = 1'b0;
   int         m_id = 0;
   int         m_ptr = 0;
   logic [3:0] s_req = '0;
   bit         s_mode = 1'b0;
   bit         s_hold = 1'b0;
   int         wait_cnt [NR];
   logic [3:0] exp_g;

   assign exp_g = m_valid ? (4'b0001 << m_id) : 4'b0000;

   function automatic int fixed_winner(input logic [3:0] r);
      for (int i = 0; i < NR; i++) if (r[i]) return i;
      return -1;
   endfunction

   function automatic int rr_winner(input logic [3:0] r, input int p);
      for (int i = 0; i < NR; i++) if (r[(p + i) % NR]) return (p + i) % NR;
      return -1;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_valid <= 1'b0;
         m_id    <= 0;
         m_ptr   <= 0;
         s_req   <= '0;
         s_mode  <= 1'b0;
         s_hold  <= 1'b0;
      end else begin
         s_req  <= bus.req_i;
         s_mode <= bus.mode_i;
         s_hold <= bus.hold_i;
         if (bus.hold_i && m_valid && bus.req_i[m_id]) begin
            m_valid <= 1'b1;
         end else if (bus.req_i == 4'b0000) begin
            m_valid <= 1'b0;
         end else if (!bus.mode_i) begin
            m_id    <= fixed_winner(bus.req_i);
            m_valid <= 1'b1;
         end else begin
            m_id    <= rr_winner(bus.req_i, m_ptr);
            m_ptr   <= (rr_winner(bus.req_i, m_ptr) + 1) % NR;
            m_valid <= 1'b1;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         chk("cyc.grant", int'(bus.grant_o), int'(exp_g));
         chk("cyc.grant_id", int'(bus.grant_id_o), m_id);
         chk("cyc.valid", int'(bus.grant_valid_o), int'(m_valid));
         chk("cyc.onehot0", int'($onehot0(bus.grant_o)), 1);
         chk("cyc.granted_req", int'((bus.grant_o & ~s_req) == 4'b0000), 1);
         for (int k = 0; k < NR; k++) begin
            if (s_mode && !s_hold && s_req[k]) begin
               if (bus.grant_o[k]) begin
                  wait_cnt[k] <= 0;
               end else begin
                  chk("cyc.starve", int'(wait_cnt[k] + 1 < NR), 1);
                  wait_cnt[k] <= wait_cnt[k] + 1;
               end
            end else begin
               wait_cnt[k] <= 0;
            end
         end
      end
   end

   task automatic step(input logic [3:0] r, input bit m, input bit h);
      bus.req_i  = r;
      bus.mode_i = m;
      bus.hold_i = h;
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string name, input logic [3:0] g, input int id, input bit v);
      chk({name, ".grant"}, int'(bus.grant_o), int'(g));
      chk({name, ".id"}, int'(bus.grant_id_o), id);
      chk({name, ".valid"}, int'(bus.grant_valid_o), int'(v));
      chk({name, ".model"}, int'(exp_g), int'(g));
   endtask

   initial begin
      for (int k = 0; k < NR; k++) wait_cnt[k] = 0;
      reset_n    = 1'b0;
      bus.req_i  = 4'b0000;
      bus.mode_i = 1'b0;
      bus.hold_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_en = 1'b1;
      lit("reset", 4'b0000, 0, 1'b0);
      #2 reset_n = 1'b1;

      // Round-robin rotation over all requesters
      step(4'b1111, 1'b1, 1'b0); lit("rr0", 4'b0001, 0, 1'b1);
      step(4'b1111, 1'b1, 1'b0); lit("rr1", 4'b0010, 1, 1'b1);
      step(4'b1111, 1'b1, 1'b0); lit("rr2", 4'b0100, 2, 1'b1);
      step(4'b1111, 1'b1, 1'b0); lit("rr3", 4'b1000, 3, 1'b1);
      step(4'b1111, 1'b1, 1'b0); lit("rr4", 4'b0001, 0, 1'b1);

      // Fixed priority, then round-robin resumes from ptr = 1
      step(4'b1110, 1'b0, 1'b0); lit("fx0", 4'b0010, 1, 1'b1);
      step(4'b1111, 1'b0, 1'b0); lit("fx1", 4'b0001, 0, 1'b1);
      step(4'b1110, 1'b0, 1'b0); lit("fx2", 4'b0010, 1, 1'b1);
      step(4'b1111, 1'b0, 1'b0); lit("fx3", 4'b0001, 0, 1'b1);
      step(4'b1111, 1'b1, 1'b0); lit("fx_resume", 4'b0010, 1, 1'b1);

      // Wrap and sparse requests
      step(4'b0011, 1'b1, 1'b0); lit("wrap", 4'b0001, 0, 1'b1);
      step(4'b1001, 1'b1, 1'b0); lit("sparse", 4'b1000, 3, 1'b1);

      // Hold, request drop, hold across mode change
      step(4'b0110, 1'b1, 1'b1); lit("hold0", 4'b0010, 1, 1'b1);
      for (int i = 1; i < 4; i++) begin
         step(4'b0110, 1'b1, 1'b1); lit("hold", 4'b0010, 1, 1'b1);
      end
      step(4'b0100, 1'b1, 1'b1); lit("hold_drop", 4'b0100, 2, 1'b1);
      step(4'b0100, 1'b0, 1'b1); lit("hold_mode", 4'b0100, 2, 1'b1);

      // Idle keeps the last id; hold without a grant arbitrates normally
      step(4'b0000, 1'b1, 1'b0); lit("idle", 4'b0000, 2, 1'b0);
      step(4'b1000, 1'b1, 1'b1); lit("hold_nogrant", 4'b1000, 3, 1'b1);

      // Asynchronous reset between edges
      step(4'b1111, 1'b1, 1'b0); lit("pre_rst0", 4'b0001, 0, 1'b1);
      step(4'b1111, 1'b1, 1'b0); lit("pre_rst1", 4'b0010, 1, 1'b1);
      #2 reset_n = 1'b0;
      #1 lit("async_rst", 4'b0000, 0, 1'b0);
      #2 reset_n = 1'b1;
      step(4'b1111, 1'b1, 1'b0); lit("post_rst", 4'b0001, 0, 1'b1);
      step(4'b0000, 1'b1, 1'b0); lit("idle2", 4'b0000, 0, 1'b0);

      // Random traffic, checked every cycle against the model
      for (int i = 0; i < 1000; i++) begin
         step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      end

      check_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
